// File: rtl/stack_pkg.sv
// Shared opcode, error-code and FSM-state encodings for the stack command sequencer.
package stack_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_DROP  = 4'h2;
    localparam logic [3:0] OP_DUP   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_EQ    = 4'h9;
    localparam logic [3:0] OP_LT    = 4'hA;
    localparam logic [3:0] OP_NOT   = 4'hB;
    localparam logic [3:0] OP_NEG   = 4'hC;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_ILL   = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POPB  = 3'd1;
    localparam logic [2:0] ST_WAITB = 3'd2;
    localparam logic [2:0] ST_POPA  = 3'd3;
    localparam logic [2:0] ST_WAITA = 3'd4;
    localparam logic [2:0] ST_PUSH1 = 3'd5;
    localparam logic [2:0] ST_PUSH2 = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

endpackage

// File: rtl/stack_alu.sv
// Combinational stack ALU: a is the deeper operand, b the top of stack.
module stack_alu #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res
);
    import stack_pkg::*;

    always_comb begin
        res = '0;
        case (op)
            OP_DROP, OP_DUP: res = a;
            OP_ADD:          res = a + b;
            OP_SUB:          res = a - b;
            OP_AND:          res = a & b;
            OP_OR:           res = a | b;
            OP_XOR:          res = a ^ b;
            OP_EQ:           res[0] = (a == b);
            OP_LT:           res[0] = (a < b);
            OP_NOT:          res = ~a;
            OP_NEG:          res = '0 - a;
            default:         res = '0;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Decode-side stack command sequencer: turns one accepted command into LIFO
// pop/push strobes, computes the result and returns a one-cycle response.
module stack_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [OP_W-1:0]   CMD_OP,
    input  logic [DATA_W-1:0] CMD_IMM,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic [1:0]        RSP_ERR,
    output logic              STK_PUSH,
    output logic [DATA_W-1:0] STK_PUSH_DATA,
    output logic              STK_POP,
    input  logic              STK_POP_VALID,
    input  logic [DATA_W-1:0] STK_POP_DATA,
    input  logic              STK_FULL,
    input  logic              STK_EMPTY
);
    import stack_pkg::*;

    logic [2:0]        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [1:0]        err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic              stk_push_q, stk_push_d;
    logic [DATA_W-1:0] stk_push_data_q, stk_push_data_d;
    logic              stk_pop_q, stk_pop_d;
    logic [DATA_W-1:0] alu_a, alu_res;

    assign alu_a = (state_q == ST_WAITA) ? STK_POP_DATA : a_q;

    stack_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
        .op  (op_q),
        .a   (alu_a),
        .b   (b_q),
        .res (alu_res)
    );

    // Strobes are registered, so POPx/PUSH1 strobes are decided on entry using the
    // flags seen one cycle earlier; the state itself then reads back the strobe.
    // PUSH2 checks FULL in-state (strobe lands in DONE) so PUSH1's push is visible.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        a_d             = a_q;
        b_d             = b_q;
        res_d           = res_q;
        err_d           = ERR_OK;
        stk_push_d      = 1'b0;
        stk_push_data_d = stk_push_data_q;
        stk_pop_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    op_d  = CMD_OP;
                    res_d = '0;
                    case (CMD_OP)
                        OP_NOP: state_d = ST_DONE;
                        OP_PUSHI: begin
                            res_d           = CMD_IMM;
                            state_d         = ST_PUSH1;
                            stk_push_d      = !STK_FULL;
                            stk_push_data_d = CMD_IMM;
                        end
                        OP_DROP, OP_DUP, OP_NOT, OP_NEG: begin
                            state_d   = ST_POPA;
                            stk_pop_d = !STK_EMPTY;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_EQ, OP_LT: begin
                            state_d   = ST_POPB;
                            stk_pop_d = !STK_EMPTY;
                        end
                        default: begin
                            state_d = ST_DONE;
                            err_d   = ERR_ILL;
                        end
                    endcase
                end
            end
            ST_POPB, ST_POPA: begin
                if (stk_pop_q) begin
                    state_d = (state_q == ST_POPB) ? ST_WAITB : ST_WAITA;
                end else begin
                    state_d = ST_DONE;
                    err_d   = ERR_UNDER;
                end
            end
            ST_WAITB: begin
                if (STK_POP_VALID) begin
                    b_d       = STK_POP_DATA;
                    state_d   = ST_POPA;
                    stk_pop_d = !STK_EMPTY;
                end
            end
            ST_WAITA: begin
                if (STK_POP_VALID) begin
                    a_d   = STK_POP_DATA;
                    res_d = alu_res;
                    if (op_q == OP_DROP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d         = ST_PUSH1;
                        stk_push_d      = !STK_FULL;
                        stk_push_data_d = alu_res;
                    end
                end
            end
            ST_PUSH1: begin
                if (!stk_push_q) begin
                    state_d = ST_DONE;
                    err_d   = ERR_OVER;
                end else begin
                    state_d = (op_q == OP_DUP) ? ST_PUSH2 : ST_DONE;
                end
            end
            ST_PUSH2: begin
                state_d = ST_DONE;
                if (STK_FULL) begin
                    err_d = ERR_OVER;
                end else begin
                    stk_push_d      = 1'b1;
                    stk_push_data_d = res_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
        rsp_err_d   = rsp_valid_d ? err_d : ERR_OK;
        rsp_data_d  = (rsp_valid_d && err_d == ERR_OK) ? res_d : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            op_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            res_q           <= '0;
            cmd_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_err_q       <= '0;
            stk_push_q      <= 1'b0;
            stk_push_data_q <= '0;
            stk_pop_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            a_q             <= a_d;
            b_q             <= b_d;
            res_q           <= res_d;
            cmd_ready_q     <= cmd_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
            stk_push_q      <= stk_push_d;
            stk_push_data_q <= stk_push_data_d;
            stk_pop_q       <= stk_pop_d;
        end
    end

    assign CMD_READY     = cmd_ready_q;
    assign RSP_VALID     = rsp_valid_q;
    assign RSP_DATA      = rsp_data_q;
    assign RSP_ERR       = rsp_err_q;
    assign STK_PUSH      = stk_push_q;
    assign STK_PUSH_DATA = stk_push_data_q;
    assign STK_POP       = stk_pop_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench: behavioural 1024-deep LIFO plus a reference stack whose
// expected responses are queued at issue time and compared when RSP_VALID fires.
module tb_stack_op_sequencer;

    localparam int DEPTH = 1024;
    localparam logic [3:0] T_NOP = 4'h0, T_PUSHI = 4'h1, T_DROP = 4'h2, T_DUP = 4'h3;
    localparam logic [3:0] T_ADD = 4'h4, T_SUB = 4'h5, T_AND = 4'h6, T_OR = 4'h7;
    localparam logic [3:0] T_XOR = 4'h8, T_EQ = 4'h9, T_LT = 4'hA, T_NOT = 4'hB, T_NEG = 4'hC;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [3:0] CMD_OP = '0;
    logic [7:0] CMD_IMM = '0;
    logic       RSP_VALID;
    logic [7:0] RSP_DATA;
    logic [1:0] RSP_ERR;
    logic       STK_PUSH;
    logic [7:0] STK_PUSH_DATA;
    logic       STK_POP;
    logic       STK_POP_VALID;
    logic [7:0] STK_POP_DATA;
    logic       STK_FULL;
    logic       STK_EMPTY;

    stack_op_sequencer #(.DATA_W(8), .OP_W(4)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .CMD_VALID     (CMD_VALID),
        .CMD_READY     (CMD_READY),
        .CMD_OP        (CMD_OP),
        .CMD_IMM       (CMD_IMM),
        .RSP_VALID     (RSP_VALID),
        .RSP_DATA      (RSP_DATA),
        .RSP_ERR       (RSP_ERR),
        .STK_PUSH      (STK_PUSH),
        .STK_PUSH_DATA (STK_PUSH_DATA),
        .STK_POP       (STK_POP),
        .STK_POP_VALID (STK_POP_VALID),
        .STK_POP_DATA  (STK_POP_DATA),
        .STK_FULL      (STK_FULL),
        .STK_EMPTY     (STK_EMPTY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural LIFO: data returned one cycle after the pop strobe.
    logic [7:0] mem [DEPTH];
    int cnt = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    logic       pv = 1'b0;
    logic [7:0] pd = '0;
    always @(posedge CLK) begin
        if (RST) begin
            cnt <= 0;
            pv  <= 1'b0;
            pd  <= '0;
        end else begin
            pv <= 1'b0;
            if (STK_PUSH) push_cnt <= push_cnt + 1;
            if (STK_POP) pop_cnt <= pop_cnt + 1;
            if (STK_PUSH && cnt < DEPTH) begin
                mem[cnt] <= STK_PUSH_DATA;
                cnt      <= cnt + 1;
            end else if (STK_POP && cnt > 0) begin
                pv  <= 1'b1;
                pd  <= mem[cnt-1];
                cnt <= cnt - 1;
            end
        end
    end
    assign STK_POP_VALID = pv;
    assign STK_POP_DATA  = pd;
    assign STK_FULL      = (cnt == DEPTH);
    assign STK_EMPTY     = (cnt == 0);

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        logic [1:0] err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] rs[$];
    int n_cmp = 0;
    int n_bad = 0;
    int last_rsp_cyc = 0;
    int last_gap = 0;

    task automatic model(input logic [3:0] op, input logic [7:0] imm,
                         output logic [7:0] d, output logic [1:0] er, output int lat);
        logic [7:0] a, b, r;
        d = '0; er = 2'd0; lat = 0; r = '0;
        case (op)
            T_NOP: lat = 1;
            T_PUSHI: begin
                lat = 2;
                if (rs.size() >= DEPTH) er = 2'd2;
                else begin rs.push_back(imm); d = imm; end
            end
            T_DROP: begin
                if (rs.size() == 0) begin er = 2'd1; lat = 2; end
                else begin d = rs.pop_back(); lat = 3; end
            end
            T_DUP: begin
                if (rs.size() == 0) begin er = 2'd1; lat = 2; end
                else begin
                    a = rs.pop_back();
                    rs.push_back(a);
                    lat = 5;
                    if (rs.size() >= DEPTH) er = 2'd2;
                    else begin rs.push_back(a); d = a; end
                end
            end
            T_NOT, T_NEG: begin
                if (rs.size() == 0) begin er = 2'd1; lat = 2; end
                else begin
                    a = rs.pop_back();
                    r = (op == T_NOT) ? ~a : 8'd0 - a;
                    rs.push_back(r); d = r; lat = 4;
                end
            end
            T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_EQ, T_LT: begin
                if (rs.size() == 0) begin er = 2'd1; lat = 2; end
                else begin
                    b = rs.pop_back();
                    if (rs.size() == 0) begin er = 2'd1; lat = 4; end
                    else begin
                        a = rs.pop_back();
                        case (op)
                            T_ADD:   r = a + b;
                            T_SUB:   r = a - b;
                            T_AND:   r = a & b;
                            T_OR:    r = a | b;
                            T_XOR:   r = a ^ b;
                            T_EQ:    r = (a == b) ? 8'd1 : 8'd0;
                            default: r = (a < b) ? 8'd1 : 8'd0;
                        endcase
                        rs.push_back(r); d = r; lat = 6;
                    end
                end
            end
            default: begin er = 2'd3; lat = 1; end
        endcase
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (STK_PUSH || STK_POP) begin
                n_cmp++;
                if (STK_PUSH && STK_POP) begin
                    n_bad++;
                    $display("FAIL strobe_overlap cyc=%0d push=%b pop=%b required not both", cyc, STK_PUSH, STK_POP);
                end
            end
            if (RSP_VALID) begin
                last_rsp_cyc = cyc;
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rsp cyc=%0d data=%h err=%0d required no response", cyc, RSP_DATA, RSP_ERR);
                end else begin
                    e = sbq.pop_front();
                    if (RSP_DATA !== e.data) begin
                        n_bad++;
                        $display("FAIL rsp_data op=%h got=%h exp=%h", e.op, RSP_DATA, e.data);
                    end
                    n_cmp++;
                    if (RSP_ERR !== e.err) begin
                        n_bad++;
                        $display("FAIL rsp_err op=%h got=%0d exp=%0d", e.op, RSP_ERR, e.err);
                    end
                    n_cmp++;
                    if (cyc - e.acc !== e.lat) begin
                        n_bad++;
                        $display("FAIL rsp_latency op=%h got=%0d exp=%0d", e.op, cyc - e.acc, e.lat);
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] imm, input bit expect_rsp);
        exp_t e;
        int t = 0;
        while (!CMD_READY && t < 50) begin @(negedge CLK); t++; end
        if (!CMD_READY) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout op=%h got ready=%b exp 1", op, CMD_READY);
        end
        last_gap  = cyc - last_rsp_cyc;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_IMM   = imm;
        if (expect_rsp) begin
            model(op, imm, e.data, e.err, e.lat);
            e.op  = op;
            e.acc = cyc;
            sbq.push_back(e);
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_OP    = '0;
        CMD_IMM   = '0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 200) begin @(negedge CLK); t++; end
        if (sbq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout got pending=%0d exp 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        rs.delete();
        sbq.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (CMD_READY !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", CMD_READY); end
        n_cmp++; if (RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", RSP_VALID); end
        n_cmp++; if (RSP_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_data got=%h exp=00", RSP_DATA); end
        n_cmp++; if (RSP_ERR !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_err got=%0d exp=0", RSP_ERR); end
        n_cmp++; if (STK_PUSH !== 1'b0) begin n_bad++; $display("FAIL reset_push got=%b exp=0", STK_PUSH); end
        n_cmp++; if (STK_POP !== 1'b0) begin n_bad++; $display("FAIL reset_pop got=%b exp=0", STK_POP); end
        n_cmp++; if (STK_PUSH_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_push_data got=%h exp=00", STK_PUSH_DATA); end
    endtask

    task automatic test_sub();
        send(T_PUSHI, 8'h05, 1'b1);
        send(T_PUSHI, 8'h03, 1'b1);
        send(T_SUB, 8'h00, 1'b1);
        drain();
        n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL sub_depth got=%0d exp=1", cnt); end
        n_cmp++; if (mem[0] !== 8'h02) begin n_bad++; $display("FAIL sub_top got=%h exp=02", mem[0]); end
    endtask

    task automatic test_add_latency();
        apply_reset();
        send(T_PUSHI, 8'h01, 1'b1);
        send(T_PUSHI, 8'h02, 1'b1);
        send(T_ADD, 8'h00, 1'b1);
        drain();
    endtask

    task automatic test_underflow();
        int p0;
        apply_reset();
        p0 = pop_cnt;
        send(T_ADD, 8'h00, 1'b1);
        drain();
        n_cmp++; if (pop_cnt - p0 !== 0) begin n_bad++; $display("FAIL underflow_no_pop got=%0d exp=0", pop_cnt - p0); end
        send(T_PUSHI, 8'h07, 1'b1);
        send(T_ADD, 8'h00, 1'b1);
        drain();
        n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL underflow_b_consumed got=%0d exp=0", cnt); end
    endtask

    task automatic test_arith();
        apply_reset();
        send(T_PUSHI, 8'hFF, 1'b1); send(T_PUSHI, 8'h01, 1'b1); send(T_ADD, 8'h00, 1'b1);
        send(T_PUSHI, 8'h02, 1'b1); send(T_PUSHI, 8'h03, 1'b1); send(T_LT, 8'h00, 1'b1);
        send(T_PUSHI, 8'h01, 1'b1); send(T_NEG, 8'h00, 1'b1);
        drain();
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            logic [7:0] imm;
            op  = 4'($urandom_range(0, 15));
            imm = 8'($urandom);
            if (i % 3 == 0) op = T_PUSHI;
            send(op, imm, 1'b1);
        end
        drain();
        n_cmp++; if (cnt !== rs.size()) begin n_bad++; $display("FAIL arith_depth got=%0d exp=%0d", cnt, rs.size()); end
    endtask

    task automatic test_overflow();
        int pu0;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] v;
            v = 8'(i) ^ 8'h5A;
            send(T_PUSHI, v, 1'b1);
        end
        drain();
        n_cmp++; if (STK_FULL !== 1'b1) begin n_bad++; $display("FAIL fill_full got=%b exp=1 depth=%0d", STK_FULL, cnt); end
        pu0 = push_cnt;
        send(T_PUSHI, 8'hAA, 1'b1);
        drain();
        n_cmp++; if (push_cnt - pu0 !== 0) begin n_bad++; $display("FAIL overflow_no_push got=%0d exp=0", push_cnt - pu0); end
        send(T_DROP, 8'h00, 1'b1);
        send(T_DUP, 8'h00, 1'b1);
        drain();
        n_cmp++; if (cnt !== DEPTH) begin n_bad++; $display("FAIL dup_one_copy got=%0d exp=%0d", cnt, DEPTH); end
    endtask

    task automatic test_reset_midop();
        int n_rsp = 0;
        apply_reset();
        send(T_PUSHI, 8'h01, 1'b1);
        send(T_PUSHI, 8'h02, 1'b1);
        drain();
        send(T_ADD, 8'h00, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        rs.delete();
        n_cmp++; if (CMD_READY !== 1'b1) begin n_bad++; $display("FAIL midreset_ready got=%b exp=1", CMD_READY); end
        repeat (10) begin
            if (RSP_VALID) n_rsp++;
            @(negedge CLK);
        end
        n_cmp++; if (n_rsp !== 0) begin n_bad++; $display("FAIL midreset_no_rsp got=%0d exp=0", n_rsp); end
        n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL midreset_lifo got=%0d exp=0", cnt); end
    endtask

    task automatic test_illegal();
        int p0, pu0;
        send(T_PUSHI, 8'h09, 1'b1);
        drain();
        p0  = pop_cnt;
        pu0 = push_cnt;
        send(4'hE, 8'h33, 1'b1);
        drain();
        n_cmp++; if (pop_cnt - p0 !== 0) begin n_bad++; $display("FAIL illegal_no_pop got=%0d exp=0", pop_cnt - p0); end
        n_cmp++; if (push_cnt - pu0 !== 0) begin n_bad++; $display("FAIL illegal_no_push got=%0d exp=0", push_cnt - pu0); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [6];
        logic [7:0] imms [6];
        ops  = '{T_PUSHI, T_PUSHI, T_OR, T_NOP, T_DUP, T_AND};
        imms = '{8'h10, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            send(ops[i], imms[i], 1'b1);
            if (i > 0) begin
                n_cmp++;
                if (last_gap !== 1) begin
                    n_bad++;
                    $display("FAIL back_to_back_gap idx=%0d got=%0d exp=1", i, last_gap);
                end
            end
        end
        drain();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog cyc=%0d exp finish before 1ms", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_sub();
        test_add_latency();
        test_underflow();
        test_arith();
        test_overflow();
        test_reset_midop();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
